// File: rtl/inhibit_hold_bank.sv
// rtl/inhibit_hold_bank.sv - multi-channel registered inhibit gate with per-channel hold stretch
//
// Purpose:
//   inh1[i] = en & in1[i] & ~blocked_i, registered. A channel is blocked while
//   in2[i] is high and for HOLD further cycles after in2[i] falls, so short
//   inhibit pulses still block reliably. Channels are fully independent.
//
// Optional feature (macro INHIBIT_STATS_EN):
//   defined   -> blk_cnt counts edges where any channel had in1=1 while blocked,
//                saturating at 2^STAT_W-1; stat_clr clears it.
//   undefined -> blk_cnt tied to 0, stat_clr ignored.
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous reset, active-high
//   en          in   1       output enable; masks inh1 only
//   in1         in   WIDTH   per-channel data/request
//   in2         in   WIDTH   per-channel inhibit
//   stat_clr    in   1       synchronous clear of blk_cnt
//   inh1        out  WIDTH   registered gated output
//   inh_active  out  WIDTH   registered channel-blocked flag
//   blk_cnt     out  STAT_W  saturating suppressed-cycle count

module inhibit_hold_bank #(
   parameter int WIDTH  = 4,
   parameter int HOLD   = 3,
   parameter int STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [WIDTH-1:0]  in1,
   input  logic [WIDTH-1:0]  in2,
   input  logic              stat_clr,
   output logic [WIDTH-1:0]  inh1,
   output logic [WIDTH-1:0]  inh_active,
   output logic [STAT_W-1:0] blk_cnt
);

   localparam int CNT_W = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD);

   logic [WIDTH-1:0][CNT_W-1:0] hcnt_q, hcnt_d;
   logic [WIDTH-1:0]            inh1_q, inh1_d;
   logic [WIDTH-1:0]            inh_active_q, inh_active_d;
   logic [WIDTH-1:0]            blocked;

   // blocked uses the pre-edge counter, so the hold window is in2 edge plus HOLD cycles.
   // A high in2 reloads the counter ahead of any decrement, which gives retriggering.
   always_comb begin
      hcnt_d  = hcnt_q;
      blocked = '0;
      for (int i = 0; i < WIDTH; i++) begin
         blocked[i] = in2[i] | (hcnt_q[i] != '0);
         if (in2[i]) begin
            hcnt_d[i] = HOLD_V;
         end else if (hcnt_q[i] != '0) begin
            hcnt_d[i] = hcnt_q[i] - CNT_W'(1);
         end
      end
      inh1_d       = {WIDTH{en}} & in1 & ~blocked;
      inh_active_d = blocked;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q       <= '0;
         inh1_q       <= '0;
         inh_active_q <= '0;
      end else begin
         hcnt_q       <= hcnt_d;
         inh1_q       <= inh1_d;
         inh_active_q <= inh_active_d;
      end
   end

   assign inh1       = inh1_q;
   assign inh_active = inh_active_q;

`ifdef INHIBIT_STATS_EN
   logic [STAT_W-1:0] blk_cnt_q, blk_cnt_d;

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (stat_clr) begin
         blk_cnt_d = '0;
      end else if ((|(in1 & blocked)) && (blk_cnt_q != '1)) begin
         blk_cnt_d = blk_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_q <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign blk_cnt = blk_cnt_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign blk_cnt         = '0;
`endif

endmodule
